// File: rtl/rvee_bus_arb.sv
// rtl/rvee_bus_arb.sv - two-port fetch/data arbiter for the single core memory bus
//
// Shares one memory bus between instruction fetch and mem-stage data accesses,
// keeping at most one transaction outstanding (IDLE -> REQ -> RESP -> IDLE).
// Contention alternates ownership using last_owner; a pipeline flush (if_kill)
// suppresses the response of a pending or outstanding fetch.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr/if_kill       fetch request, address, flush
//   if_gnt/if_rvalid             fetch accept pulse, fetch response pulse
//   d_req/d_we/d_addr/d_wdata/d_be  data request and payload
//   d_gnt/d_rvalid/d_err         data accept pulse, response/ack pulse, error
//   rdata                        response data shared by both ports
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be  bus request and registered payload
//   bus_gnt/bus_rvalid/bus_rdata/bus_err      bus accept, response, data, error

module rvee_bus_arb #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [XLEN-1:0]   rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_t state_q, state_d;
  logic   owner_q;
  logic   last_owner_q;
  logic   kill_q;
  logic   any_req;
  logic   fetch_wins;

  // On contention the side that did not own the previous transaction wins.
  // last_owner resets to FETCH, so the first simultaneous request goes to DATA.
  always_comb begin
    any_req = if_req | d_req;
    if (if_req && d_req) begin
      fetch_wins = (last_owner_q == OWN_DATA);
    end else begin
      fetch_wins = if_req;
    end
  end

  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    d_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          if_gnt  = (owner_q == OWN_FETCH);
          d_gnt   = (owner_q == OWN_DATA);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus_rvalid) begin
          // A flush in the response cycle itself also drops the fetch.
          if_rvalid = (owner_q == OWN_FETCH) && !kill_q && !if_kill;
          d_rvalid  = (owner_q == OWN_DATA);
          d_err     = (owner_q == OWN_DATA) && bus_err;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdata = bus_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      kill_q       <= 1'b0;
      bus_we       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q      <= fetch_wins ? OWN_FETCH : OWN_DATA;
            last_owner_q <= fetch_wins ? OWN_FETCH : OWN_DATA;
            kill_q       <= fetch_wins && if_kill;
            bus_we       <= fetch_wins ? 1'b0 : d_we;
          end else begin
            kill_q <= 1'b0;
          end
        end
        S_REQ, S_RESP: begin
          if (state_d == S_IDLE) begin
            kill_q <= 1'b0;
          end else if (owner_q == OWN_FETCH && if_kill) begin
            kill_q <= 1'b1;
          end
        end
        default: begin
          kill_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload is don't-care out of reset, so it carries no reset term.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && any_req) begin
      if (fetch_wins) begin
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        bus_be    <= '1;
      end else begin
        bus_addr  <= d_addr;
        bus_wdata <= d_wdata;
        bus_be    <= d_be;
      end
    end
  end

endmodule
